// File: rtl/if_instr_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : if_instr_mem_pipe_if
// Brief    : Fetch and programming bus of the IF-stage instruction memory.
// Revision : 1.0
// ============================================================================
interface if_instr_mem_pipe_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_stall;
    logic        i_flush;
    logic        i_prog_we;
    logic [31:0] i_prog_addr;
    logic [31:0] i_prog_data;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_fault_mis;
    logic        o_fault_oob;
    logic        o_prog_err;

    modport master (
        output i_req, i_addr, i_stall, i_flush, i_prog_we, i_prog_addr, i_prog_data,
        input  o_instr, o_valid, o_fault_mis, o_fault_oob, o_prog_err
    );

    modport slave (
        input  i_req, i_addr, i_stall, i_flush, i_prog_we, i_prog_addr, i_prog_data,
        output o_instr, o_valid, o_fault_mis, o_fault_oob, o_prog_err
    );
endinterface
`default_nettype wire

// File: rtl/if_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : if_instr_mem_pipe
// Brief    : Writable instruction RAM with a LATENCY-stage fetch pipeline,
//            stall/flush, fault flagging and a programming port.
// Revision : 1.0
// ============================================================================
module if_instr_mem_pipe #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    if_instr_mem_pipe_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("if_instr_mem_pipe: LATENCY must be in 1..4");
    end
    if (DEPTH < 16 || DEPTH > 65536 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("if_instr_mem_pipe: DEPTH must be a power of two in 16..65536");
    end

    logic [31:0] mem [DEPTH];

    logic [31:0]        fetch_off, prog_off, rd_data;
    logic               fetch_mis, fetch_oob, prog_ok, mem_we, accept;
    logic [AW-1:0]      fetch_idx, prog_idx;

    logic [LATENCY-1:0] valid_q, valid_d, mis_q, mis_d, oob_q, oob_d;
    logic [31:0]        instr_q [LATENCY];
    logic [31:0]        instr_d [LATENCY];
    logic               prog_err_q, prog_err_d;

    // Offsets wrap below BASE_ADDR; the explicit compare keeps them from aliasing.
    always_comb begin
        fetch_off = bus.i_addr - BASE_ADDR;
        fetch_mis = |bus.i_addr[1:0];
        fetch_oob = (bus.i_addr < BASE_ADDR) || ((fetch_off >> 2) >= 32'(DEPTH));
        fetch_idx = fetch_off[AW+1:2];
        rd_data   = (fetch_mis || fetch_oob) ? NOP_INSTR : mem[fetch_idx];

        prog_off   = bus.i_prog_addr - BASE_ADDR;
        prog_ok    = (bus.i_prog_addr[1:0] == 2'b00) && (bus.i_prog_addr >= BASE_ADDR)
                     && ((prog_off >> 2) < 32'(DEPTH));
        prog_idx   = prog_off[AW+1:2];
        mem_we     = bus.i_prog_we && prog_ok && !i_rst;
        prog_err_d = bus.i_prog_we && !prog_ok;

        accept = bus.i_req && !bus.i_stall && !bus.i_flush;
    end

    // Array is never reset so a debug loader's image survives a core reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[prog_idx] <= bus.i_prog_data;
        end
    end

    // Instr fields advance only with a valid entry, so the output word
    // naturally holds its last delivered value across bubbles and flushes.
    always_comb begin
        valid_d = valid_q;
        mis_d   = mis_q;
        oob_d   = oob_q;
        instr_d = instr_q;
        if (bus.i_flush) begin
            valid_d = '0;
        end else if (!bus.i_stall) begin
            valid_d[0] = accept;
            if (accept) begin
                instr_d[0] = rd_data;
                mis_d[0]   = fetch_mis;
                oob_d[0]   = fetch_oob;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    instr_d[k] = instr_q[k-1];
                    mis_d[k]   = mis_q[k-1];
                    oob_d[k]   = oob_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= '0;
            mis_q      <= '0;
            oob_q      <= '0;
            prog_err_q <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                instr_q[k] <= NOP_INSTR;
            end
        end else begin
            valid_q    <= valid_d;
            mis_q      <= mis_d;
            oob_q      <= oob_d;
            prog_err_q <= prog_err_d;
            instr_q    <= instr_d;
        end
    end

    assign bus.o_instr     = instr_q[LATENCY-1];
    assign bus.o_valid     = valid_q[LATENCY-1];
    assign bus.o_fault_mis = valid_q[LATENCY-1] & mis_q[LATENCY-1];
    assign bus.o_fault_oob = valid_q[LATENCY-1] & oob_q[LATENCY-1];
    assign bus.o_prog_err  = prog_err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_instr_mem_pipe
// Brief    : Four instances (LATENCY 1..4) driven in lockstep against a
//            list-of-in-flight-fetches reference model.
// Revision : 1.0
// ============================================================================
module tb_if_instr_mem_pipe;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, stall = 1'b0, flush = 1'b0, pwe = 1'b0;
    logic [31:0] addr = '0, paddr = '0, pdata = '0;

    logic [31:0] o_instr_a [4];
    logic        o_valid_a [4];
    logic        o_mis_a   [4];
    logic        o_oob_a   [4];
    logic        o_perr_a  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        if_instr_mem_pipe_if bus ();
        assign bus.i_req       = req;
        assign bus.i_addr      = addr;
        assign bus.i_stall     = stall;
        assign bus.i_flush     = flush;
        assign bus.i_prog_we   = pwe;
        assign bus.i_prog_addr = paddr;
        assign bus.i_prog_data = pdata;
        if_instr_mem_pipe #(
            .DEPTH(DEPTH), .LATENCY(g + 1), .BASE_ADDR(BASE), .NOP_INSTR(NOP)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );
        assign o_instr_a[g] = bus.o_instr;
        assign o_valid_a[g] = bus.o_valid;
        assign o_mis_a[g]   = bus.o_fault_mis;
        assign o_oob_a[g]   = bus.o_fault_oob;
        assign o_perr_a[g]  = bus.o_prog_err;
    end

    // Reference: each accepted fetch waits LATENCY-1 unstalled edges, then is shown.
    typedef struct {
        logic [31:0] instr;
        logic        mis;
        logic        oob;
        int          rem;
    } ent_t;

    ent_t        pend [4][8];
    int          npend [4];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_instr [4];
    logic        exp_valid [4];
    logic        exp_mis   [4];
    logic        exp_oob   [4];
    logic        exp_perr;
    logic [31:0] w [4];
    int          vec  = 0;
    int          miss = 0;

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            npend[l]     = 0;
            exp_valid[l] = 1'b0;
            exp_instr[l] = NOP;
            exp_mis[l]   = 1'b0;
            exp_oob[l]   = 1'b0;
        end
        exp_perr = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] off, rdata;
        logic        mis, oob, pbad;
        int          n;
        if (rst) begin
            model_reset();
            return;
        end
        off   = addr - BASE;
        mis   = addr[1:0] != 2'b00;
        oob   = (addr < BASE) || ((off >> 2) >= 32'(DEPTH));
        rdata = NOP;
        if (!mis && !oob) rdata = mem_m[int'(off >> 2)];
        off      = paddr - BASE;
        pbad     = (paddr[1:0] != 2'b00) || (paddr < BASE) || ((off >> 2) >= 32'(DEPTH));
        exp_perr = pwe && pbad;
        if (pwe && !pbad) mem_m[int'(off >> 2)] = pdata;
        for (int l = 0; l < 4; l++) begin
            if (flush) begin
                npend[l] = 0;
            end else if (!stall) begin
                n = 0;
                for (int i = 0; i < npend[l]; i++) begin
                    if (pend[l][i].rem > 0) begin
                        pend[l][n]     = pend[l][i];
                        pend[l][n].rem = pend[l][i].rem - 1;
                        n++;
                    end
                end
                if (req) begin
                    pend[l][n] = '{instr: rdata, mis: mis, oob: oob, rem: l};
                    n++;
                end
                npend[l] = n;
            end
            exp_valid[l] = 1'b0;
            exp_mis[l]   = 1'b0;
            exp_oob[l]   = 1'b0;
            for (int i = 0; i < npend[l]; i++) begin
                if (pend[l][i].rem == 0) begin
                    exp_valid[l] = 1'b1;
                    exp_instr[l] = pend[l][i].instr;
                    exp_mis[l]   = pend[l][i].mis;
                    exp_oob[l]   = pend[l][i].oob;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int l = 0; l < 4; l++) begin
            vec++;
            if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l]} !== {1'b0, NOP, 3'b000}) begin
                miss++;
                $display("FAIL reset L=%0d got v=%b i=%h m=%b o=%b e=%b want v=0 i=%h flags 0",
                         l + 1, o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l], NOP);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        for (int i = 0; i < DEPTH; i++) begin
            pwe   = 1'b1;
            paddr = BASE + 32'(4 * i);
            pdata = (i < 4) ? w[i] : (i == 5) ? NOP : $urandom;
            tick();
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_perr_a[l]} !== {exp_valid[l], exp_perr}) begin
                    miss++;
                    $display("FAIL program L=%0d got v=%b e=%b want v=%b e=%b",
                             l + 1, o_valid_a[l], o_perr_a[l], exp_valid[l], exp_perr);
                end
            end
        end
        pwe = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            req  = (k < 4);
            addr = BASE + 32'(4 * (k % 4));
            tick();
            if (k < 4) begin
                vec++;
                if ({o_valid_a[0], o_instr_a[0], o_mis_a[0], o_oob_a[0]} !== {1'b1, w[k], 2'b00}) begin
                    miss++;
                    $display("FAIL b2b_word%0d got v=%b i=%h m=%b o=%b want v=1 i=%h",
                             k, o_valid_a[0], o_instr_a[0], o_mis_a[0], o_oob_a[0], w[k]);
                end
            end
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l]} !== {exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l], exp_perr}) begin
                    miss++;
                    $display("FAIL b2b L=%0d got v=%b i=%h want v=%b i=%h",
                             l + 1, o_valid_a[l], o_instr_a[l], exp_valid[l], exp_instr[l]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int seen = 0, first = -1;
        for (int k = 0; k < 8; k++) begin
            req   = (k == 0);
            addr  = BASE;
            stall = (k == 2 || k == 3);
            tick();
            if (o_valid_a[2] === 1'b1) begin
                seen++;
                if (first < 0) first = k;
            end
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l]} !== {exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l]}) begin
                    miss++;
                    $display("FAIL stall L=%0d k=%0d got v=%b i=%h want v=%b i=%h",
                             l + 1, k, o_valid_a[l], o_instr_a[l], exp_valid[l], exp_instr[l]);
                end
            end
        end
        stall = 1'b0;
        vec++;
        if (seen != 1 || first != 4 || o_instr_a[2] !== w[0]) begin
            miss++;
            $display("FAIL stall_l3 got count=%0d first=%0d i=%h want count=1 first=4 i=%h",
                     seen, first, o_instr_a[2], w[0]);
        end
    endtask

    task automatic test_faults();
        logic [31:0] fa [4];
        logic [1:0]  ff [4];
        fa[0] = BASE + 32'd2;      ff[0] = 2'b10;
        fa[1] = BASE + DEPTH * 4;  ff[1] = 2'b01;
        fa[2] = 32'h0000_0000;     ff[2] = 2'b01;
        fa[3] = BASE - 32'd1;      ff[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req  = 1'b1;
            addr = fa[k];
            tick();
            vec++;
            if ({o_valid_a[0], o_instr_a[0], o_mis_a[0], o_oob_a[0]} !== {1'b1, NOP, ff[k]}) begin
                miss++;
                $display("FAIL fault_%0h got v=%b i=%h m=%b o=%b want v=1 i=%h m=%b o=%b",
                         fa[k], o_valid_a[0], o_instr_a[0], o_mis_a[0], o_oob_a[0], NOP, ff[k][1], ff[k][0]);
            end
        end
        req   = 1'b0;
        pwe   = 1'b1;
        paddr = BASE + 32'd1;
        pdata = 32'hFFFF_FFFF;
        tick();
        pwe = 1'b0;
        vec++;
        if (o_perr_a[0] !== 1'b1) begin
            miss++;
            $display("FAIL prog_err_pulse got %b want 1", o_perr_a[0]);
        end
        req  = 1'b1;
        addr = BASE;
        tick();
        req = 1'b0;
        vec++;
        if ({o_perr_a[0], o_valid_a[0], o_instr_a[0]} !== {1'b0, 1'b1, w[0]}) begin
            miss++;
            $display("FAIL prog_err_clear got e=%b v=%b i=%h want e=0 v=1 i=%h",
                     o_perr_a[0], o_valid_a[0], o_instr_a[0], w[0]);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l]} !== {exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l], exp_perr}) begin
                    miss++;
                    $display("FAIL fault_drain L=%0d got v=%b i=%h want v=%b i=%h",
                             l + 1, o_valid_a[l], o_instr_a[l], exp_valid[l], exp_instr[l]);
                end
            end
        end
    endtask

    task automatic test_flush();
        req = 1'b1;
        addr = BASE;
        tick();
        addr = BASE + 32'd4;
        tick();
        flush = 1'b1;
        addr  = BASE + 32'd8;
        tick();
        flush = 1'b0;
        req   = 1'b0;
        vec++;
        if (o_valid_a[1] !== 1'b0) begin
            miss++;
            $display("FAIL flush_edge got v=%b want 0", o_valid_a[1]);
        end
        tick();
        vec++;
        if (o_valid_a[1] !== 1'b0) begin
            miss++;
            $display("FAIL flush_after got v=%b want 0", o_valid_a[1]);
        end
        req  = 1'b1;
        addr = BASE + 32'd12;
        tick();
        req = 1'b0;
        tick();
        vec++;
        if ({o_valid_a[1], o_instr_a[1]} !== {1'b1, w[3]}) begin
            miss++;
            $display("FAIL flush_refetch got v=%b i=%h want v=1 i=%h", o_valid_a[1], o_instr_a[1], w[3]);
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_collision();
        pwe   = 1'b1;
        paddr = BASE + 32'd20;
        pdata = 32'hDEAD_BEEF;
        req   = 1'b1;
        addr  = BASE + 32'd20;
        tick();
        pwe = 1'b0;
        req = 1'b0;
        vec++;
        if ({o_valid_a[0], o_instr_a[0]} !== {1'b1, NOP}) begin
            miss++;
            $display("FAIL collide_old got v=%b i=%h want v=1 i=%h", o_valid_a[0], o_instr_a[0], NOP);
        end
        for (int k = 0; k < 3; k++) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        vec++;
        if ({o_valid_a[0], o_instr_a[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
            miss++;
            $display("FAIL collide_new got v=%b i=%h want v=1 i=deadbeef", o_valid_a[0], o_instr_a[0]);
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req   = ($urandom_range(0, 3) != 0);
            addr  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            pwe   = ($urandom_range(0, 4) == 0);
            paddr = ($urandom_range(0, 5) == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            pdata = $urandom;
            tick();
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l]} !== {exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l], exp_perr}) begin
                    miss++;
                    $display("FAIL random L=%0d k=%0d got v=%b i=%h m=%b o=%b e=%b want v=%b i=%h m=%b o=%b e=%b",
                             l + 1, k, o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l], o_perr_a[l],
                             exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l], exp_perr);
                end
            end
        end
        {req, stall, flush, pwe} = 4'b0000;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) begin
            req  = 1'b1;
            addr = BASE + 32'(4 * k);
            tick();
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int l = 0; l < 4; l++) begin
            vec++;
            if ({o_valid_a[l], o_instr_a[l]} !== {1'b0, NOP}) begin
                miss++;
                $display("FAIL async_rst L=%0d got v=%b i=%h want v=0 i=%h", l + 1, o_valid_a[l], o_instr_a[l], NOP);
            end
        end
        pwe   = 1'b1;
        paddr = BASE;
        pdata = 32'h1234_5678;
        tick();
        tick();
        pwe = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            req  = (k < DEPTH);
            addr = BASE + 32'(4 * (k % DEPTH));
            tick();
            for (int l = 0; l < 4; l++) begin
                vec++;
                if ({o_valid_a[l], o_instr_a[l], o_mis_a[l], o_oob_a[l]} !== {exp_valid[l], exp_instr[l], exp_mis[l], exp_oob[l]}) begin
                    miss++;
                    $display("FAIL post_rst L=%0d k=%0d got v=%b i=%h want v=%b i=%h",
                             l + 1, k, o_valid_a[l], o_instr_a[l], exp_valid[l], exp_instr[l]);
                end
            end
        end
        req = 1'b0;
    endtask

    initial begin
        w[0] = 32'h0010_0093;
        w[1] = 32'h0011_0113;
        w[2] = 32'h00AB_F437;
        w[3] = 32'h01B3_8393;
        model_reset();
        test_reset();
        test_program();
        test_back_to_back();
        test_stall();
        test_faults();
        test_flush();
        test_collision();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
